rf_wb_arbiter: RTL and testbench
================================

# rf_wb_arbiter

Write-port controller for the 16 x 8 accumulator-machine register file. It owns the file's single write port and shares it between the ALU writeback path and the load/store unit's load-return path. It sequences a post-reset zero-fill sweep of every register. It also keeps a pending-load scoreboard that raises hazard flags to the decode stage. The block sits between execute/LSU and the register file's write_en/address/data inputs.

## Interface
- W, 8, data path width
- D, 4, register pointer width; 2**D registers
- CLK  in  1  clock
- reset  in  1  reset, synchronous, active-high
- alu_valid  in  1  ALU has a writeback
- alu_addr  in  D  ALU destination register
- alu_data  in  W  ALU result
- alu_ready  out  1  ALU writeback accepted this cycle
- lsu_issue  in  1  load issued; destination becomes pending
- lsu_issue_addr  in  D  destination of issued load
- lsu_valid  in  1  load data returning; cannot be stalled
- lsu_addr  in  D  destination of returning load
- lsu_data  in  W  returned load data
- chk_addrA  in  D  decode source pointer A (rs)
- chk_addrB  in  D  decode source pointer B (r0/accumulator)
- hazardA  out  1  source A not yet valid
- hazardB  out  1  source B not yet valid
- clr_busy  out  1  zero-fill sweep in progress; core must stall
- rf_we  out  1  register file write enable
- rf_waddr  out  D  register file write address
- rf_wdata  out  W  register file write data
- pend_mask  out  2**D  pending-load scoreboard, bit i = register i
- sb_err  out  1  sticky scoreboard protocol error

## Operation
- There are two states, CLEAR and RUN. reset forces CLEAR, clr_ptr=0, pend_mask=0, and sb_err=0.
- While reset is high, the block holds rf_we=0, alu_ready=0, clr_busy=1, hazardA=hazardB=1, and rf_waddr=rf_wdata=0.
- CLEAR:
  - Drives rf_we=1, rf_waddr=clr_ptr, rf_wdata=0; clr_ptr increments each cycle.
  - After the write of register 2**D-1, the next state is RUN.
  - alu_ready=0. lsu_issue and lsu_valid are ignored and do not update the scoreboard. hazardA=hazardB=1.
- RUN, write-port priority:
  - LSU return first. If lsu_valid, drive rf_we=1, rf_waddr=lsu_addr, rf_wdata=lsu_data, and alu_ready=0.
  - ALU second. Otherwise alu_ready = !pend_mask[alu_addr]. A WAW against an outstanding load blocks the ALU.
  - When alu_valid and alu_ready are both high, drive rf_we=1, rf_waddr=alu_addr, rf_wdata=alu_data.
  - Otherwise rf_we=0.
- ALU handshake: the transfer happens when alu_valid and alu_ready are both high. The ALU holds its addr and data stable while valid and not ready.
- Scoreboard updates, at the clock edge, in RUN only:
  - lsu_valid clears bit lsu_addr.
  - lsu_issue sets bit lsu_issue_addr.
  - If both target the same register, set wins (the new load is outstanding).
- sb_err sets, and stays set until reset, in either of these cases:
  - lsu_issue to an already pending register that is not being cleared that same cycle.
  - lsu_valid to a non-pending register. The write is still performed.
- hazardA = pend_mask[chk_addrA] in RUN; hazardB likewise for chk_addrB. A same-cycle lsu_valid is not bypassed, so the hazard drops the cycle after the return.
- pend_mask and sb_err are registered outputs. rf_*, alu_ready and hazard* are combinational from registered state and current inputs.

## Timing
- Write latency: rf_* are valid in the request cycle, and the register file commits at that cycle's CLK edge.
- Sweep:
  - The first reset-low cycle writes r0.
  - clr_busy stays high for exactly 2**D cycles after reset deasserts (16 at D=4).
  - The first ALU acceptance is possible in cycle 2**D+1.
- A scoreboard bit set by lsu_issue is visible on pend_mask/hazard the cycle after issue.
- Reset mid-sweep restarts the sweep at r0. Reset with loads outstanding discards pend_mask; late lsu_valid pulses during the new CLEAR are ignored.
- An ALU write blocked by an LSU return has no starvation bound. The LSU guarantees it returns at most 1 load per 2 cycles.

## Structure
- Shared package (definitions): state enum (CLEAR, RUN) and kNumRegs = 2**D.
- One natural sub-module: rf_scoreboard. It contains pend_mask, the set/clear/err logic and the hazard lookup. The arbiter contains the FSM, clr_ptr and the write mux.

## Test plan
- Release reset at cycle 0 → rf_we=1 with rf_waddr 0..15 and rf_wdata=0 on cycles 0..15. clr_busy falls at cycle 16, and alu_ready=1 with alu_addr=3 and pend_mask=0.
- RUN: alu_valid, addr 5, data 0xA7 → rf_we=1, rf_waddr=5, rf_wdata=0xA7, alu_ready=1 in the same cycle.
- alu_valid (addr 2, 0x11) and lsu_valid (addr 9, 0x3C) in the same cycle → write 9/0x3C with alu_ready=0. Next cycle write 2/0x11.
- lsu_issue addr 4 → pend_mask=0x0010 the next cycle and hazardA=1 with chk_addrA=4. alu_valid to addr 4 sees alu_ready=0. lsu_valid addr 4, 0x5E → write performed, and pend_mask=0 and hazardA=0 the following cycle.
- Same cycle lsu_valid addr 6 (pending) and lsu_issue addr 6 → bit 6 remains set and sb_err=0. Then lsu_valid to addr 7 (not pending) → write occurs and sb_err=1, sticky.
- Issue a load to addr 8, then assert reset for 1 cycle at sweep-independent time → pend_mask=0 and a full 16-cycle sweep follows. A lsu_valid in sweep cycle 3 does not alter rf_waddr=3 or pend_mask.

Source files
------------

// File: rtl/rf_wb_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// rf_wb_arbiter_pkg
// Shared definitions for the register-file write-port arbiter slice.
//   kW        : data path width
//   kD        : register pointer width
//   kNumRegs  : number of registers (2**kD)
//   state_e   : arbiter state (CLEAR = zero-fill sweep, RUN = normal operation)
// ----------------------------------------------------------------------------
package rf_wb_arbiter_pkg;

   localparam int kW       = 8;
   localparam int kD       = 4;
   localparam int kNumRegs = 2**kD;

   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_e;

endpackage

// File: rtl/rf_wb_arbiter_scoreboard.sv
// ----------------------------------------------------------------------------
// rf_scoreboard
// Pending-load scoreboard. One bit per register, set when a load to that
// register is issued and cleared when its data returns. Also flags protocol
// errors (double issue, return without issue) and answers hazard lookups.
// Ports:
//   CLK, reset          : clock, synchronous active-high reset
//   run                 : arbiter is in RUN and not in reset; updates gated by it
//   lsu_issue/_addr     : load issued to register
//   lsu_valid/lsu_addr  : load returning to register
//   chk_addrA/B         : decode source pointers to look up
//   alu_addr            : ALU destination, looked up for WAW blocking
//   hazardA/B           : source not yet valid (forced high outside RUN)
//   alu_blocked         : ALU destination has an outstanding load
//   pend_mask           : registered scoreboard
//   sb_err              : registered sticky protocol error
// ----------------------------------------------------------------------------
module rf_scoreboard
   import rf_wb_arbiter_pkg::*;
#(
   parameter int D = kD
) (
   input  logic            CLK,
   input  logic            reset,
   input  logic            run,
   input  logic            lsu_issue,
   input  logic [D-1:0]    lsu_issue_addr,
   input  logic            lsu_valid,
   input  logic [D-1:0]    lsu_addr,
   input  logic [D-1:0]    chk_addrA,
   input  logic [D-1:0]    chk_addrB,
   input  logic [D-1:0]    alu_addr,
   output logic            hazardA,
   output logic            hazardB,
   output logic            alu_blocked,
   output logic [2**D-1:0] pend_mask,
   output logic            sb_err
);

   localparam int N = 2**D;

   logic [N-1:0] pend_mask_q, pend_mask_d;
   logic         sb_err_q, sb_err_d;
   logic         same_reg_s;

   assign same_reg_s = lsu_valid && (lsu_addr == lsu_issue_addr);

   // Next-state scoreboard: clear on return first, then set on issue so set wins.
   always_comb begin
      pend_mask_d = pend_mask_q;
      sb_err_d    = sb_err_q;
      if (run) begin
         if (lsu_valid) begin
            if (!pend_mask_q[lsu_addr]) begin
               sb_err_d = 1'b1;
            end else begin
               sb_err_d = sb_err_d;
            end
            pend_mask_d[lsu_addr] = 1'b0;
         end else begin
            pend_mask_d = pend_mask_d;
         end
         if (lsu_issue) begin
            // Re-issue is legal only if the same register retires this cycle.
            if (pend_mask_q[lsu_issue_addr] && !same_reg_s) begin
               sb_err_d = 1'b1;
            end else begin
               sb_err_d = sb_err_d;
            end
            pend_mask_d[lsu_issue_addr] = 1'b1;
         end else begin
            pend_mask_d = pend_mask_d;
         end
      end else begin
         pend_mask_d = pend_mask_q;
         sb_err_d    = sb_err_q;
      end
   end

   // Hazard and WAW lookups; same-cycle returns are deliberately not bypassed.
   always_comb begin
      alu_blocked = pend_mask_q[alu_addr];
      if (run) begin
         hazardA = pend_mask_q[chk_addrA];
         hazardB = pend_mask_q[chk_addrB];
      end else begin
         hazardA = 1'b1;
         hazardB = 1'b1;
      end
   end

   // Scoreboard and error flops.
   always_ff @(posedge CLK) begin
      if (reset) begin
         pend_mask_q <= {N{1'b0}};
         sb_err_q    <= 1'b0;
      end else begin
         pend_mask_q <= pend_mask_d;
         sb_err_q    <= sb_err_d;
      end
   end

   assign pend_mask = pend_mask_q;
   assign sb_err    = sb_err_q;

endmodule

// File: rtl/rf_wb_arbiter.sv
// ----------------------------------------------------------------------------
// rf_wb_arbiter
// Owns the single write port of the 16 x 8 register file. After reset it
// sweeps zeros into every register (CLEAR), then in RUN arbitrates the port
// between LSU load returns (highest priority, never stalled) and ALU
// writebacks (valid/ready). A pending-load scoreboard blocks ALU WAW writes
// and drives hazard flags to decode.
// Ports:
//   CLK, reset                      : clock, synchronous active-high reset
//   alu_valid/addr/data, alu_ready  : ALU writeback handshake
//   lsu_issue, lsu_issue_addr       : load issue (marks destination pending)
//   lsu_valid/addr/data             : load return
//   chk_addrA/B, hazardA/B          : decode hazard lookup
//   clr_busy                        : zero-fill sweep in progress
//   rf_we/waddr/wdata               : register file write port
//   pend_mask, sb_err               : scoreboard state and sticky error
// ----------------------------------------------------------------------------
module rf_wb_arbiter
   import rf_wb_arbiter_pkg::*;
#(
   parameter int W = kW,
   parameter int D = kD
) (
   input  logic            CLK,
   input  logic            reset,
   input  logic            alu_valid,
   input  logic [D-1:0]    alu_addr,
   input  logic [W-1:0]    alu_data,
   output logic            alu_ready,
   input  logic            lsu_issue,
   input  logic [D-1:0]    lsu_issue_addr,
   input  logic            lsu_valid,
   input  logic [D-1:0]    lsu_addr,
   input  logic [W-1:0]    lsu_data,
   input  logic [D-1:0]    chk_addrA,
   input  logic [D-1:0]    chk_addrB,
   output logic            hazardA,
   output logic            hazardB,
   output logic            clr_busy,
   output logic            rf_we,
   output logic [D-1:0]    rf_waddr,
   output logic [W-1:0]    rf_wdata,
   output logic [2**D-1:0] pend_mask,
   output logic            sb_err
);

   state_e         state_q, state_d;
   logic [D-1:0]   clr_ptr_q, clr_ptr_d;
   logic           run_s;
   logic           alu_blocked_s;

   // Reset is synchronous, so the registered state is stale while it is high.
   assign run_s = (state_q == ST_RUN) && !reset;

   rf_scoreboard #(.D(D)) u_sb (
      .CLK            (CLK),
      .reset          (reset),
      .run            (run_s),
      .lsu_issue      (lsu_issue),
      .lsu_issue_addr (lsu_issue_addr),
      .lsu_valid      (lsu_valid),
      .lsu_addr       (lsu_addr),
      .chk_addrA      (chk_addrA),
      .chk_addrB      (chk_addrB),
      .alu_addr       (alu_addr),
      .hazardA        (hazardA),
      .hazardB        (hazardB),
      .alu_blocked    (alu_blocked_s),
      .pend_mask      (pend_mask),
      .sb_err         (sb_err)
   );

   // FSM and sweep pointer next-state.
   always_comb begin
      state_d   = state_q;
      clr_ptr_d = clr_ptr_q;
      case (state_q)
         ST_CLEAR: begin
            clr_ptr_d = clr_ptr_q + {{(D-1){1'b0}}, 1'b1};
            if (clr_ptr_q == {D{1'b1}}) begin
               state_d = ST_RUN;
            end else begin
               state_d = ST_CLEAR;
            end
         end
         ST_RUN: begin
            state_d = ST_RUN;
         end
         default: begin
            state_d   = ST_CLEAR;
            clr_ptr_d = {D{1'b0}};
         end
      endcase
   end

   // Write-port mux: reset hold, sweep, then LSU return over ALU writeback.
   always_comb begin
      rf_we     = 1'b0;
      rf_waddr  = {D{1'b0}};
      rf_wdata  = {W{1'b0}};
      alu_ready = 1'b0;
      clr_busy  = 1'b1;
      if (reset) begin
         clr_busy = 1'b1;
      end else if (state_q == ST_CLEAR) begin
         rf_we    = 1'b1;
         rf_waddr = clr_ptr_q;
      end else begin
         clr_busy = 1'b0;
         if (lsu_valid) begin
            rf_we    = 1'b1;
            rf_waddr = lsu_addr;
            rf_wdata = lsu_data;
         end else begin
            alu_ready = !alu_blocked_s;
            if (alu_valid && !alu_blocked_s) begin
               rf_we    = 1'b1;
               rf_waddr = alu_addr;
               rf_wdata = alu_data;
            end else begin
               rf_we = 1'b0;
            end
         end
      end
   end

   // State and sweep pointer flops.
   always_ff @(posedge CLK) begin
      if (reset) begin
         state_q   <= ST_CLEAR;
         clr_ptr_q <= {D{1'b0}};
      end else begin
         state_q   <= state_d;
         clr_ptr_q <= clr_ptr_d;
      end
   end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// ----------------------------------------------------------------------------
// tb_rf_wb_arbiter
// Self-checking bench for rf_wb_arbiter: stimulus steps push their expected
// outputs into a queue; a negedge monitor pops and compares.
// ----------------------------------------------------------------------------
module tb_rf_wb_arbiter;

   logic        CLK;
   logic        reset;
   logic        alu_valid;
   logic [3:0]  alu_addr;
   logic [7:0]  alu_data;
   logic        alu_ready;
   logic        lsu_issue;
   logic [3:0]  lsu_issue_addr;
   logic        lsu_valid;
   logic [3:0]  lsu_addr;
   logic [7:0]  lsu_data;
   logic [3:0]  chk_addrA;
   logic [3:0]  chk_addrB;
   logic        hazardA;
   logic        hazardB;
   logic        clr_busy;
   logic        rf_we;
   logic [3:0]  rf_waddr;
   logic [7:0]  rf_wdata;
   logic [15:0] pend_mask;
   logic        sb_err;

   rf_wb_arbiter #(.W(8), .D(4)) dut (
      .CLK(CLK), .reset(reset),
      .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
      .lsu_issue(lsu_issue), .lsu_issue_addr(lsu_issue_addr),
      .lsu_valid(lsu_valid), .lsu_addr(lsu_addr), .lsu_data(lsu_data),
      .chk_addrA(chk_addrA), .chk_addrB(chk_addrB), .hazardA(hazardA), .hazardB(hazardB),
      .clr_busy(clr_busy), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .pend_mask(pend_mask), .sb_err(sb_err)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic       av; logic [3:0] aa; logic [7:0] ad;
      logic       li; logic [3:0] lia;
      logic       lv; logic [3:0] la; logic [7:0] ld;
      logic [3:0] ca; logic [3:0] cb;
   } in_t;

   typedef struct {
      int          tag;
      logic        we; logic [3:0] wa; logic [7:0] wd;
      logic        rdy; logic busy; logic ha; logic hb;
      logic [15:0] pend; logic err;
   } exp_t;

   typedef struct { in_t i; exp_t e; } vec_t;

   exp_t exp_q[$];
   vec_t tbl[14];
   int   checks = 0;
   int   errors = 0;

   function automatic in_t mk_in(logic av, logic [3:0] aa, logic [7:0] ad, logic li,
                                 logic [3:0] lia, logic lv, logic [3:0] la, logic [7:0] ld,
                                 logic [3:0] ca, logic [3:0] cb);
      in_t r;
      r.av = av; r.aa = aa; r.ad = ad; r.li = li; r.lia = lia;
      r.lv = lv; r.la = la; r.ld = ld; r.ca = ca; r.cb = cb;
      return r;
   endfunction

   function automatic exp_t mk_exp(logic we, logic [3:0] wa, logic [7:0] wd, logic rdy,
                                   logic busy, logic ha, logic hb, logic [15:0] pend, logic err);
      exp_t r;
      r.tag = 0; r.we = we; r.wa = wa; r.wd = wd; r.rdy = rdy; r.busy = busy;
      r.ha = ha; r.hb = hb; r.pend = pend; r.err = err;
      return r;
   endfunction

   task automatic chk(input string name, input int tag, input logic [15:0] act, input logic [15:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s step %0d: got %0h expected %0h", name, tag, act, want);
      end
   endtask

   // Drive one cycle of inputs and queue the outputs expected in that cycle.
   task automatic step(input int tag, input in_t i, input exp_t e);
      alu_valid = i.av; alu_addr = i.aa; alu_data = i.ad;
      lsu_issue = i.li; lsu_issue_addr = i.lia;
      lsu_valid = i.lv; lsu_addr = i.la; lsu_data = i.ld;
      chk_addrA = i.ca; chk_addrB = i.cb;
      e.tag = tag;
      exp_q.push_back(e);
      @(posedge CLK);
      #1;
   endtask

   // Monitor: compare queued expectations mid-cycle, away from the clock edge.
   always @(negedge CLK) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk("rf_we",     e.tag, {15'd0, rf_we},     {15'd0, e.we});
         if (e.we || e.busy) begin
            chk("rf_waddr", e.tag, {12'd0, rf_waddr}, {12'd0, e.wa});
            chk("rf_wdata", e.tag, {8'd0, rf_wdata},  {8'd0, e.wd});
         end
         chk("alu_ready", e.tag, {15'd0, alu_ready}, {15'd0, e.rdy});
         chk("clr_busy",  e.tag, {15'd0, clr_busy},  {15'd0, e.busy});
         chk("hazardA",   e.tag, {15'd0, hazardA},   {15'd0, e.ha});
         chk("hazardB",   e.tag, {15'd0, hazardB},   {15'd0, e.hb});
         chk("pend_mask", e.tag, pend_mask,          e.pend);
         chk("sb_err",    e.tag, {15'd0, sb_err},    {15'd0, e.err});
      end
   end

   in_t idle;

   initial begin
      idle = mk_in(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b0, 4'd0, 8'h00, 4'd0, 4'd0);
      // Post-sweep and RUN vectors (inputs, expected outputs in that cycle).
      tbl[0]  = '{mk_in(1'b0,4'd3,8'h00,1'b0,4'd0,1'b0,4'd0,8'h00,4'd0,4'd0), mk_exp(1'b0,4'd0,8'h00,1'b1,1'b0,1'b0,1'b0,16'h0000,1'b0)};
      tbl[1]  = '{mk_in(1'b1,4'd5,8'hA7,1'b1,4'd9,1'b0,4'd0,8'h00,4'd0,4'd0), mk_exp(1'b1,4'd5,8'hA7,1'b1,1'b0,1'b0,1'b0,16'h0000,1'b0)};
      tbl[2]  = '{mk_in(1'b1,4'd2,8'h11,1'b0,4'd0,1'b1,4'd9,8'h3C,4'd9,4'd0), mk_exp(1'b1,4'd9,8'h3C,1'b0,1'b0,1'b1,1'b0,16'h0200,1'b0)};
      tbl[3]  = '{mk_in(1'b1,4'd2,8'h11,1'b0,4'd0,1'b0,4'd0,8'h00,4'd9,4'd0), mk_exp(1'b1,4'd2,8'h11,1'b1,1'b0,1'b0,1'b0,16'h0000,1'b0)};
      tbl[4]  = '{mk_in(1'b0,4'd4,8'h00,1'b1,4'd4,1'b0,4'd0,8'h00,4'd4,4'd0), mk_exp(1'b0,4'd0,8'h00,1'b1,1'b0,1'b0,1'b0,16'h0000,1'b0)};
      tbl[5]  = '{mk_in(1'b1,4'd4,8'h77,1'b0,4'd0,1'b0,4'd0,8'h00,4'd4,4'd0), mk_exp(1'b0,4'd0,8'h00,1'b0,1'b0,1'b1,1'b0,16'h0010,1'b0)};
      tbl[6]  = '{mk_in(1'b1,4'd4,8'h77,1'b0,4'd0,1'b1,4'd4,8'h5E,4'd4,4'd0), mk_exp(1'b1,4'd4,8'h5E,1'b0,1'b0,1'b1,1'b0,16'h0010,1'b0)};
      tbl[7]  = '{mk_in(1'b1,4'd4,8'h77,1'b0,4'd0,1'b0,4'd0,8'h00,4'd4,4'd0), mk_exp(1'b1,4'd4,8'h77,1'b1,1'b0,1'b0,1'b0,16'h0000,1'b0)};
      tbl[8]  = '{mk_in(1'b0,4'd0,8'h00,1'b1,4'd6,1'b0,4'd0,8'h00,4'd0,4'd6), mk_exp(1'b0,4'd0,8'h00,1'b1,1'b0,1'b0,1'b0,16'h0000,1'b0)};
      tbl[9]  = '{mk_in(1'b0,4'd0,8'h00,1'b1,4'd6,1'b1,4'd6,8'h66,4'd0,4'd6), mk_exp(1'b1,4'd6,8'h66,1'b0,1'b0,1'b0,1'b1,16'h0040,1'b0)};
      tbl[10] = '{mk_in(1'b0,4'd0,8'h00,1'b0,4'd0,1'b0,4'd0,8'h00,4'd0,4'd6), mk_exp(1'b0,4'd0,8'h00,1'b1,1'b0,1'b0,1'b1,16'h0040,1'b0)};
      tbl[11] = '{mk_in(1'b0,4'd0,8'h00,1'b0,4'd0,1'b1,4'd7,8'h99,4'd0,4'd6), mk_exp(1'b1,4'd7,8'h99,1'b0,1'b0,1'b0,1'b1,16'h0040,1'b0)};
      tbl[12] = '{mk_in(1'b0,4'd0,8'h00,1'b1,4'd8,1'b0,4'd0,8'h00,4'd0,4'd6), mk_exp(1'b0,4'd0,8'h00,1'b1,1'b0,1'b0,1'b1,16'h0040,1'b1)};
      tbl[13] = '{mk_in(1'b0,4'd0,8'h00,1'b0,4'd0,1'b0,4'd0,8'h00,4'd8,4'd6), mk_exp(1'b0,4'd0,8'h00,1'b1,1'b0,1'b1,1'b1,16'h0140,1'b1)};

      alu_valid = 1'b0; alu_addr = 4'd0; alu_data = 8'h00;
      lsu_issue = 1'b0; lsu_issue_addr = 4'd0;
      lsu_valid = 1'b0; lsu_addr = 4'd0; lsu_data = 8'h00;
      chk_addrA = 4'd0; chk_addrB = 4'd0;

      // Initial reset: second held cycle shows the reset outputs.
      reset = 1'b1;
      @(posedge CLK);
      #1;
      step(100, idle, mk_exp(1'b0,4'd0,8'h00,1'b0,1'b1,1'b1,1'b1,16'h0000,1'b0));
      reset = 1'b0;

      // Zero-fill sweep: cycles 0..15 write r0..r15 with zero.
      for (int k = 0; k < 16; k++) begin
         step(200 + k, mk_in(1'b0,4'd3,8'h00,1'b0,4'd0,1'b0,4'd0,8'h00,4'd0,4'd0),
              mk_exp(1'b1, 4'(k), 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b0));
      end

      // Table-driven RUN vectors, starting at cycle 16.
      for (int k = 0; k < 14; k++) begin
         step(k, tbl[k].i, tbl[k].e);
      end

      // One-cycle reset with loads outstanding (r6, r8) and sb_err set.
      reset = 1'b1;
      step(300, idle, mk_exp(1'b0,4'd0,8'h00,1'b0,1'b1,1'b1,1'b1,16'h0140,1'b1));
      reset = 1'b0;

      // New sweep; a late return and an issue in sweep cycle 3 are ignored.
      for (int k = 0; k < 16; k++) begin
         if (k == 3) begin
            step(400 + k, mk_in(1'b0,4'd0,8'h00,1'b1,4'd2,1'b1,4'd8,8'hEE,4'd8,4'd2),
                 mk_exp(1'b1, 4'd3, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b0));
         end else begin
            step(400 + k, idle,
                 mk_exp(1'b1, 4'(k), 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b0));
         end
      end
      step(500, mk_in(1'b1,4'd8,8'h42,1'b0,4'd0,1'b0,4'd0,8'h00,4'd8,4'd2),
           mk_exp(1'b1,4'd8,8'h42,1'b1,1'b0,1'b0,1'b0,16'h0000,1'b0));

      @(negedge CLK);
      #1;
      chk("queue_drained", 999, 16'(exp_q.size()), 16'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
